if_fetch_queue: RTL

Parametrised instruction-fetch stage for the pipelined CPU. It keeps the fetch PC and drives a synchronous instruction memory with one-cycle read latency. Fetched instructions and their PCs are buffered in a small fetch queue that feeds decode through a valid/ready handshake. A branch/jump redirect kills all wrong-path work and raises a registered flush toward the IF/ID boundary.

---
 rtl/if_fetch_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with a small fetch queue.
// Keeps the fetch PC, drives a one-cycle-latency synchronous instruction
// memory, buffers returned words with their PCs, and hands them to decode.
// A redirect kills all wrong-path work and raises a registered flush.
// Optional feature macro: IF_PERF_CNT_EN adds fetch/redirect counters.
//
// Decode handshake: inst_valid is high when the queue holds an entry and no
// redirect is present this cycle. An entry is consumed (popped) on every
// cycle where inst_valid and inst_ready are both high. While inst_valid is
// high, inst and inst_pc hold their values until the pop.
module if_fetch_queue #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = 32'h00000000,
  parameter int unsigned          FQ_DEPTH = 4,
  parameter int unsigned          IMEM_AW  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect,
  input  logic [PC_WIDTH-1:0]           redirect_pc,
  output logic [IMEM_AW-1:0]            imem_addr,
  input  logic [31:0]                   imem_rdata,
  output logic [31:0]                   inst,
  output logic [PC_WIDTH-1:0]           inst_pc,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic                          flush,
  output logic [$clog2(FQ_DEPTH):0]     fq_count
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_fetch_cnt,
  output logic [31:0]                   perf_redirect_cnt
`endif
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic                r_req_valid;
  logic [PC_WIDTH-1:0] r_req_pc;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_wr_ptr;
  logic [CW-1:0]       r_count;
  logic                r_flush;
  logic [31:0]         r_q_inst [FQ_DEPTH];
  logic [PC_WIDTH-1:0] r_q_pc   [FQ_DEPTH];

  logic [CW:0]         w_occupied;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_inst_valid;
  logic [PC_WIDTH-1:0] w_target_pc;

  // Occupancy counts the in-flight request so a returning word always has a
  // slot; a same-cycle pop is deliberately not credited.
  assign w_occupied   = {1'b0, r_count} + {{CW{1'b0}}, r_req_valid};
  assign w_issue      = ~redirect & (w_occupied < (CW+1)'(FQ_DEPTH));
  assign w_push       = r_req_valid & ~redirect;
  assign w_inst_valid = (r_count != '0) & ~redirect;
  assign w_pop        = w_inst_valid & inst_ready;
  assign w_target_pc  = redirect_pc & ~PC_WIDTH'(3);

  // Upper fetch_pc bits are dropped here, so the memory aliases.
  assign imem_addr  = r_fetch_pc[IMEM_AW+1:2];
  assign inst       = r_q_inst[r_rd_ptr];
  assign inst_pc    = r_q_pc[r_rd_ptr];
  assign inst_valid = w_inst_valid;
  assign flush      = r_flush;
  assign fq_count   = r_count;

  // Fetch PC and the single outstanding memory request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else if (redirect) begin
      r_fetch_pc  <= w_target_pc;
      r_req_valid <= 1'b0;
    end else if (w_issue) begin
      r_fetch_pc  <= r_fetch_pc + PC_WIDTH'(4);
      r_req_valid <= 1'b1;
      r_req_pc    <= r_fetch_pc;
    end else begin
      r_req_valid <= 1'b0;
    end
  end

  // Queue pointers and occupancy; redirect empties the queue.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Queue storage: the returning word is written with the PC it was fetched at.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_q_inst[r_wr_ptr] <= imem_rdata;
      r_q_pc[r_wr_ptr]   <= r_req_pc;
    end
  end

  // Flush is high for exactly the cycle after each redirect cycle.
  always_ff @(posedge clk) begin
    if (reset) r_flush <= 1'b0;
    else       r_flush <= redirect;
  end

`ifdef IF_PERF_CNT_EN
  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (w_push)   perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
      if (redirect) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
